skolem_sweep_checker: RTL



---
 rtl/skolem_sweep_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep driver/checker for a combinational Skolem block: walks every x,
// samples y after SETTLE cycles and checks the XOR relation over {x, y}.
module skolem_sweep_checker #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned N_OUT  = 8,
  parameter int unsigned SETTLE = 1,
  parameter bit          PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   x_o,
  input  logic [N_OUT-1:0]  y_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     fail_count,
  output logic [N_IN-1:0]   first_fail_x,
  output logic              first_fail_valid
);

  localparam int unsigned   CW       = 4;
  localparam logic [CW-1:0] RELOAD   = CW'(SETTLE - 1);
  localparam logic [N_IN:0] FAIL_MAX = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N_IN-1:0] x_q;
  logic [N_IN-1:0] ffx_q;
  logic            ffv_q;
  logic [N_IN:0]   fail_q;
  logic [N_IN:0]   fail_d;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            err;

  // err is only consumed in ST_CHECK, so y_i outside CHECK never reaches state.
  always_comb begin
    err    = (^{x_q, y_i}) != PARITY;
    fail_d = fail_q;
    if (err && (fail_q != FAIL_MAX)) begin
      fail_d = fail_q + (N_IN+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      ffx_q   <= '0;
      ffv_q   <= 1'b0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            state_q <= ST_SETTLE;
            cnt_q   <= RELOAD;
            x_q     <= '0;
            ffx_q   <= '0;
            ffv_q   <= 1'b0;
            fail_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            fail_q <= fail_d;
            if (err && !ffv_q) begin
              ffx_q <= x_q;
              ffv_q <= 1'b1;
            end
            if (x_q == '1) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_d == '0);
            end else begin
              x_q     <= x_q + N_IN'(1);
              cnt_q   <= RELOAD;
              state_q <= ST_SETTLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x_o              = x_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_x     = ffx_q;
  assign first_fail_valid = ffv_q;

endmodule
